i2s_audio_bridge: RTL



---
 rtl/i2s_audio_bridge.sv | 139 +++++++++++++
 1 files changed

// File: rtl/i2s_audio_bridge.sv
// I2S master bridge between the 48 kHz parallel PCM interface and a stereo codec.
// Define I2S_RX_EN to build the ADC capture path (audio_li/audio_ri); otherwise they read 0.
module i2s_audio_bridge #(
  parameter int unsigned FRAME_CYCLES = 1250
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        audio_en,
  input  logic [15:0] audio_lo,
  input  logic [15:0] audio_ro,
  output logic [15:0] audio_li,
  output logic [15:0] audio_ri,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdo,
  input  logic        i2s_sdi,
  output logic        i2s_active,
  output logic        frame_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [10:0] cyc;
  logic [10:0] acc;
  logic [6:0]  t;
  logic [15:0] tx_l;
  logic [15:0] tx_r;
  logic [11:0] s;
  logic [6:0]  p;
  logic        last_cyc;
  logic        toggle;
  logic        tx_bit;

  assign s        = {1'b0, acc} + 12'd128;
  // Period index for toggle t: rising t=2p, falling t=2p-1 both map to p.
  assign p        = 7'(({1'b0, t} + 8'd1) >> 1);
  assign last_cyc = (cyc == 11'(FRAME_CYCLES - 1));
  assign toggle   = (state == RUN) && !audio_en && !last_cyc && (s >= 12'(FRAME_CYCLES));

  always_comb begin
    tx_bit = 1'b0;
    if (p >= 7'd1 && p <= 7'd16)
      tx_bit = tx_l[4'(7'd16 - p)];
    else if (p >= 7'd33 && p <= 7'd48)
      tx_bit = tx_r[4'(7'd48 - p)];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cyc        <= '0;
      acc        <= '0;
      t          <= '0;
      tx_l       <= '0;
      tx_r       <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrck   <= 1'b0;
      i2s_sdo    <= 1'b0;
      i2s_active <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (audio_en) begin
        frame_err  <= (state == RUN) && !last_cyc;
        state      <= RUN;
        i2s_active <= 1'b1;
        cyc        <= '0;
        acc        <= '0;
        t          <= '0;
        i2s_bclk   <= 1'b0;
        i2s_lrck   <= 1'b0;
        i2s_sdo    <= 1'b0;
        tx_l       <= audio_lo;
        tx_r       <= audio_ro;
      end else if (state == RUN) begin
        if (last_cyc) begin
          state      <= IDLE;
          i2s_active <= 1'b0;
          frame_err  <= 1'b1;
          i2s_bclk   <= 1'b0;
          i2s_lrck   <= 1'b0;
          i2s_sdo    <= 1'b0;
        end else begin
          cyc <= cyc + 11'd1;
          if (toggle) begin
            acc      <= 11'(s - 12'(FRAME_CYCLES));
            i2s_bclk <= ~i2s_bclk;
            t        <= t + 7'd1;
            if (t[0] && t != 7'd127) begin
              i2s_lrck <= (p >= 7'd32);
              i2s_sdo  <= tx_bit;
            end
          end else begin
            acc <= s[10:0];
          end
        end
      end
    end
  end

`ifdef I2S_RX_EN
  logic        sdi_meta;
  logic        sdi_sync;
  logic [15:0] rx_l;
  logic [15:0] rx_r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sdi_meta <= 1'b0;
      sdi_sync <= 1'b0;
      rx_l     <= '0;
      rx_r     <= '0;
      audio_li <= '0;
      audio_ri <= '0;
    end else begin
      sdi_meta <= i2s_sdi;
      sdi_sync <= sdi_meta;
      if (toggle && !t[0]) begin
        if (p >= 7'd1 && p <= 7'd16)
          rx_l <= {rx_l[14:0], sdi_sync};
        if (p >= 7'd33 && p <= 7'd48)
          rx_r <= {rx_r[14:0], sdi_sync};
        // Right LSB arrives on this same edge, so it is merged in directly.
        if (t == 7'd96) begin
          audio_li <= rx_l;
          audio_ri <= {rx_r[14:0], sdi_sync};
        end
      end
    end
  end
`else
  logic unused_sdi;
  assign unused_sdi = i2s_sdi;
  assign audio_li   = '0;
  assign audio_ri   = '0;
`endif

endmodule
